// File: rtl/sar_search.sv
// Successive-approximation search controller: drives comparator B input and resolves A MSB first.
// Optional SAR_EARLY_EXIT_EN: finish as soon as the comparator reports a clean equal.
module sar_search #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             great,
  input  logic             equal,
  input  logic             less,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t          state;
  logic [KW-1:0]   k;
  logic            keep;
  logic            onehot;
  logic [WIDTH-1:0] trial_res;  // trial with bit k resolved
  logic [WIDTH-1:0] trial_nxt;  // resolved trial plus tentative next bit

  always_comb begin
    keep      = great | equal;
    onehot    = ({1'b0, great} + {1'b0, equal} + {1'b0, less}) == 2'd1;
    trial_res = trial;
    trial_res[k] = keep;
    trial_nxt = trial_res;
    if (k != '0) trial_nxt[k - KW'(1)] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      trial  <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      k      <= KW'(WIDTH - 1);
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            trial <= {1'b1, {(WIDTH-1){1'b0}}};
            k     <= KW'(WIDTH - 1);
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= CMP;
          end
        end
        CMP: begin
          if (!onehot) err <= 1'b1;
`ifdef SAR_EARLY_EXIT_EN
          if (equal && onehot) begin
            // lower bits of trial are still 0 and A == trial, so trial is exact
            result <= trial;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else
`endif
          if (k == '0) begin
            trial  <= trial_res;
            result <= trial_res;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            trial <= trial_nxt;
            k     <= k - KW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: behavioural comparator plus bit-by-bit search model.
module tb_sar_search;
  localparam int W = 4;

  logic         clk, rst, start;
  logic         great, equal, less;
  logic [W-1:0] trial, result;
  logic         busy, done, err;
  logic [W-1:0] a;
  logic         fault;
  logic [W-1:0] last_res;
  int           n_chk, n_fail;

  sar_search #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .great(great), .equal(equal), .less(less),
    .trial(trial), .busy(busy), .done(done), .result(result), .err(err)
  );

  // Comparator model; fault forces an all-zero verdict
  assign great = fault ? 1'b0 : (a >  trial);
  assign equal = fault ? 1'b0 : (a == trial);
  assign less  = fault ? 1'b0 : (a <  trial);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Runs one search; fault_at = compare index (0-based) with a bad verdict, -1 for none
  task automatic search(input logic [W-1:0] av, input int fault_at, input bit poke);
    logic [W-1:0] r, t;
    logic [W-1:0] tq[$];
    bit ferr;
    r = '0; ferr = 0;
    for (int b = W - 1; b >= 0; b--) begin
      t = r | W'(1 << b);
      tq.push_back(t);
      if (tq.size() - 1 == fault_at) ferr = 1;
      else begin
`ifdef SAR_EARLY_EXIT_EN
        if (av == t) begin r = t; break; end
`endif
        if (av >= t) r = t;
      end
    end
    @(negedge clk); a = av; start = 1'b1;
    @(negedge clk); start = 1'b0;
    foreach (tq[j]) begin
      chk("trial", {28'd0, trial}, {28'd0, tq[j]});
      chk("busy", {31'd0, busy}, 32'd1);
      chk("done_low", {31'd0, done}, 32'd0);
      chk("result_hold", {28'd0, result}, {28'd0, last_res});
      chk("err_mid", {31'd0, err}, {31'd0, (fault_at >= 0 && j > fault_at)});
      fault = (j == fault_at);
      start = (poke && j == 1);
      @(negedge clk);
      fault = 1'b0; start = 1'b0;
    end
    chk("done", {31'd0, done}, 32'd1);
    chk("busy_done", {31'd0, busy}, 32'd0);
    chk("result", {28'd0, result}, {28'd0, r});
    chk("trial_final", {28'd0, trial}, {28'd0, r});
    chk("err", {31'd0, err}, {31'd0, ferr});
    last_res = r;
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("result_kept", {28'd0, result}, {28'd0, r});
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; fault = 1'b0; a = '0; last_res = '0;
    repeat (2) @(negedge clk);
    chk("rst_trial", {28'd0, trial}, 32'd0);
    chk("rst_result", {28'd0, result}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    search(4'd11, -1, 1'b0);
    search(4'd8,  -1, 1'b0);
    search(4'd0,  -1, 1'b0);
    search(4'd15, -1, 1'b0);
    search(4'd11, -1, 1'b1);
    search(4'd5,  -1, 1'b0);
    search(4'd11,  1, 1'b0);
    search(4'd5,  -1, 1'b0);

    // Reset in the middle of the 3rd compare
    @(negedge clk); a = 4'd9; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_trial", {28'd0, trial}, 32'd0);
    chk("mid_rst_result", {28'd0, result}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk); rst = 1'b0; last_res = '0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_done", {31'd0, done}, 32'd0);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
    end
    search(4'd6, -1, 1'b0);

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] av;
      int fa;
      av = W'($urandom_range(0, 15));
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1;
`ifdef SAR_EARLY_EXIT_EN
      fa = -1;  // fault index may lie beyond an early exit
`endif
      search(av, fa, $urandom_range(0, 1) == 1);
    end

    // start held high: one IDLE cycle after DONE, then a new search
    @(negedge clk); a = 4'd13; start = 1'b1;
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    chk("held_done", {31'd0, done}, 32'd1);
    chk("held_result", {28'd0, result}, 32'd13);
    @(negedge clk);
    chk("held_idle_busy", {31'd0, busy}, 32'd0);
    chk("held_idle_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("held_restart_busy", {31'd0, busy}, 32'd1);
    chk("held_restart_trial", {28'd0, trial}, 32'd8);
    start = 1'b0;
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    chk("held_done2", {31'd0, done}, 32'd1);
    chk("held_result2", {28'd0, result}, 32'd13);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sar_search.md
Name: sar_search

Overview:
- Successive-approximation search controller; the driving side of the team's magnitude comparators.
- Generates trial values on the comparator's B input and reads back the great/equal/less verdicts for an unknown operand A wired to the comparator's A input.
- Resolves A exactly, MSB first, and reports it on `result`.
- Used wherever a value is only observable through a comparator, e.g. threshold discovery or ADC-style digitisation.

Parameters:
- WIDTH, 4: operand width in bits; also the worst-case number of compare cycles.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  begin a search; honoured only in IDLE.
- great  input  1  comparator verdict A > trial, combinational from `trial`.
- equal  input  1  comparator verdict A == trial.
- less  input  1  comparator verdict A < trial.
- trial  output  WIDTH  value driven to the comparator B input.
- busy  output  1  high while a search is in progress.
- done  output  1  one-cycle pulse when `result` becomes valid.
- result  output  WIDTH  resolved value of A; held until the next accepted start.
- err  output  1  verdict was not one-hot during the last search; sticky until the next accepted start.

Behaviour:
- Reset (async, any state, including mid-search):
  - state=IDLE.
  - trial, result = 0.
  - busy, done, err = 0.
  - bit index = WIDTH-1.
- States: IDLE, CMP, DONE.
- IDLE:
  - On start=1 at a clock edge: trial = 1<<(WIDTH-1), bit index k = WIDTH-1, err=0, busy=1, go to CMP.
  - result keeps its old value until DONE.
- CMP: one bit resolved per clock. At each edge, sample great/equal/less against the current trial.
  - keep = great | equal.
  - trial[k] = keep.
  - If k==0: result = updated trial, go to DONE.
  - Otherwise: k = k-1, and the new trial[k] = 1 (tentative).
  - Bits above k are never changed after they are resolved.
- Verdict check: if the verdict is not exactly one-hot (none set, or more than one set), set err=1.
  - The bit is still resolved using keep = great | equal.
  - The search continues.
- DONE: lasts exactly one cycle.
  - done=1, busy=0, result valid.
  - trial holds the final value.
  - Next edge goes to IDLE and done returns to 0.
- Latency: start sampled at edge E0; compare edges E1..E(WIDTH); done high for the cycle after E(WIDTH). WIDTH=4 gives 4 compare cycles and done in cycle 5.
- start while busy or in DONE: ignored, with no effect on the search.
- start held high continuously: a new search begins on the edge after DONE returns to IDLE.
- Arithmetic: unsigned only; no carries or wrap-around. All WIDTH-bit values 0..2^WIDTH-1 are reachable.

Optional Feature:
- Macro: SAR_EARLY_EXIT_EN.
- Defined: in CMP, a sampled equal=1 with a one-hot verdict ends the search on that edge.
  - result = current trial, with all lower bits still 0, which is exact because A == trial.
  - Go to DONE.
  - Latency is variable, from 1 to WIDTH compare cycles.
- Undefined: equal is treated as great for bit decisions, and the search always runs WIDTH compare cycles. Results are identical in both builds; only latency differs.

Test Plan:
- WIDTH=4, A=11, pulse start: trial sequence 8,12,10,11; result=11; done pulses in cycle 5; err=0. With SAR_EARLY_EXIT_EN, equal occurs on the 4th compare, so timing is unchanged.
- A=8: without the macro, trials 8,12,10,9, result=8 after 4 compares. With SAR_EARLY_EXIT_EN, trial 8 only, done in cycle 2, result=8.
- A=0 gives trials 8,4,2,1 and result=0. A=15 gives trials 8,12,14,15 and result=15. Both run all 4 compares in either build.
- Back-to-back: A=11 search, then a start pulse during CMP, which must be ignored. Then start in IDLE with A=5: result=5, and result holds 11 until the second done.
- Fault injection: force great=equal=0 on the 2nd compare, with A=11 otherwise. Required: err=1 at done, bit 2 cleared, result=11 (bit 2 of 11 is 0). err clears on the next start.
- Assert rst during the 3rd compare: outputs are 0 and state is IDLE immediately, with no done pulse. A following start with A=6 gives result=6.
